// File: rtl/study_note_presenter_pkg.sv
// rtl/study_note_presenter_pkg.sv - mode codes, note encodings, FSM states and song table for study mode
package study_note_presenter_pkg;

  localparam logic [1:0] IDLE_MODE  = 2'b00;
  localparam logic [1:0] PLAY_MODE  = 2'b01;
  localparam logic [1:0] LEARN_MODE = 2'b10;

  localparam int         SONG_LEN_DEF   = 28;
  localparam logic [9:0] END_CODE_DEF   = 10'h000;
  localparam logic [9:0] NOTE_BLANK_DEF = 10'h3FF;

  typedef enum logic [2:0] {
    SNP_IDLE,
    SNP_FETCH,
    SNP_WAIT,
    SNP_LOAD,
    SNP_PRESENT,
    SNP_DONE
  } snp_state_t;

  // Song image: one-hot key in the low bits, pitch bits above. Word 3 ends the song;
  // words past the playable range are non-zero so a stray read would be visible.
  function automatic logic [9:0] song_word(input int addr);
    case (addr)
      0:       song_word = 10'h001;
      1:       song_word = 10'h002;
      2:       song_word = 10'h004;
      3:       song_word = END_CODE_DEF;
      default: song_word = (addr < SONG_LEN_DEF) ? (10'h100 | 10'(addr)) : 10'h200;
    endcase
  endfunction

endpackage

// File: rtl/study_song_rom.sv
// rtl/study_song_rom.sv - song ROM with one-cycle synchronous read
module study_song_rom
  import study_note_presenter_pkg::*;
#(
  parameter int IDX_W  = 7,
  parameter int NOTE_W = 10
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  addr,
  output logic [NOTE_W-1:0] data
);

  always_ff @(posedge clk) begin
    data <= NOTE_W'(song_word(int'(addr)));
  end

endmodule

// File: rtl/study_note_presenter.sv
// rtl/study_note_presenter.sv - study-mode expected-note source and key hint; STUDY_HINT_BLINK_EN blinks the hint
module study_note_presenter
  import study_note_presenter_pkg::*;
#(
  parameter int              IDX_W      = 7,
  parameter int              NOTE_W     = 10,
  parameter int              SONG_LEN   = SONG_LEN_DEF,
  parameter logic [NOTE_W-1:0] END_CODE   = NOTE_W'(END_CODE_DEF),
  parameter logic [NOTE_W-1:0] NOTE_BLANK = NOTE_W'(NOTE_BLANK_DEF),
  parameter int              BLINK_DIV  = 25_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        state,
  input  logic [IDX_W-1:0]  index,
  output logic [NOTE_W-1:0] note_expect,
  output logic              note_valid,
  output logic [NOTE_W-1:0] led_hint,
  output logic              song_done
);

  if (BLINK_DIV < 1 || SONG_LEN < 1) begin : g_param_check
    $error("study_note_presenter: BLINK_DIV and SONG_LEN must be positive");
  end

  snp_state_t        fsm;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  rom_addr;
  logic [NOTE_W-1:0] rom_data;
  logic [IDX_W-1:0]  idx_m1;
  logic              blink;

  assign idx_m1 = index - IDX_W'(1);

  study_song_rom #(
    .IDX_W  (IDX_W),
    .NOTE_W (NOTE_W)
  ) u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .data (rom_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm         <= SNP_IDLE;
      idx_q       <= '0;
      rom_addr    <= '0;
      note_expect <= NOTE_BLANK;
      note_valid  <= 1'b0;
      song_done   <= 1'b0;
    end else if (state != LEARN_MODE) begin
      fsm         <= SNP_IDLE;
      note_expect <= NOTE_BLANK;
      note_valid  <= 1'b0;
      song_done   <= 1'b0;
    end else begin
      case (fsm)
        SNP_IDLE: fsm <= SNP_FETCH;
        SNP_FETCH: begin
          idx_q <= index;
          // index 0 means the learner has not started; wait here with a blank output
          if (index == '0) begin
            fsm <= SNP_FETCH;
          end else if (int'(idx_m1) >= SONG_LEN) begin
            fsm       <= SNP_DONE;
            song_done <= 1'b1;
          end else begin
            rom_addr <= idx_m1;
            fsm      <= SNP_WAIT;
          end
        end
        SNP_WAIT: fsm <= SNP_LOAD;
        SNP_LOAD: begin
          if (rom_data == END_CODE) begin
            fsm       <= SNP_DONE;
            song_done <= 1'b1;
          end else begin
            note_expect <= rom_data;
            note_valid  <= 1'b1;
            fsm         <= SNP_PRESENT;
          end
        end
        SNP_PRESENT: begin
          if (index != idx_q) begin
            note_expect <= NOTE_BLANK;
            note_valid  <= 1'b0;
            fsm         <= SNP_FETCH;
          end
        end
        SNP_DONE: begin
          song_done   <= 1'b1;
          note_expect <= NOTE_BLANK;
          note_valid  <= 1'b0;
        end
        default: fsm <= SNP_IDLE;
      endcase
    end
  end

`ifdef STUDY_HINT_BLINK_EN
  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0] blink_cnt;

  // Every freshly loaded hint restarts lit so the learner sees it at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt <= '0;
      blink     <= 1'b1;
    end else if (fsm == SNP_LOAD) begin
      blink_cnt <= '0;
      blink     <= 1'b1;
    end else if (fsm == SNP_PRESENT) begin
      if (blink_cnt == CNT_MAX) begin
        blink_cnt <= '0;
        blink     <= ~blink;
      end else begin
        blink_cnt <= blink_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign blink = 1'b1;
`endif

  assign led_hint = note_valid ? (note_expect & {NOTE_W{blink}}) : '0;

endmodule

// File: tb/tb_study_note_presenter.sv
// tb/tb_study_note_presenter.sv - randomized self-checking bench for study_note_presenter
module tb_study_note_presenter;
  import study_note_presenter_pkg::*;

  localparam int BDIV = 4;
`ifdef STUDY_HINT_BLINK_EN
  localparam bit BLINK_BUILD = 1'b1;
`else
  localparam bit BLINK_BUILD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state;
  logic [6:0] index;
  logic [9:0] note_expect;
  logic       note_valid;
  logic [9:0] led_hint;
  logic       song_done;

  int total = 0;
  int passed = 0;
  logic [9:0] rom_img [0:127];

  always #5 clk = ~clk;

  study_note_presenter #(.BLINK_DIV(BDIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .state       (state),
    .index       (index),
    .note_expect (note_expect),
    .note_valid  (note_valid),
    .led_hint    (led_hint),
    .song_done   (song_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [9:0] got, input logic [9:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else passed++;
  endtask

  function automatic bit model_done(input int idx);
    return (idx >= 1) && ((idx - 1 >= 28) || (rom_img[idx-1] == 10'h000));
  endfunction

  task automatic test_reset();
    rst = 1'b0; state = LEARN_MODE; index = 7'd1;
    repeat (3) tick();
    chk("reset_note", note_expect, 10'h3FF);
    chk("reset_valid", {9'd0, note_valid}, 10'd0);
    chk("reset_led", led_hint, 10'h000);
    chk("reset_done", {9'd0, song_done}, 10'd0);
  endtask

  task automatic test_first_note();
    rst = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk($sformatf("entry_valid_e%0d", e), {9'd0, note_valid}, 10'd0);
    end
    tick();
    chk("entry_note", note_expect, 10'h001);
    chk("entry_valid", {9'd0, note_valid}, 10'd1);
    chk("entry_led", led_hint, 10'h001);
  endtask

  task automatic test_step();
    index = 7'd2;
    tick();
    chk("step_k_note", note_expect, 10'h3FF);
    chk("step_k_valid", {9'd0, note_valid}, 10'd0);
    tick();
    tick();
    chk("step_k2_valid", {9'd0, note_valid}, 10'd0);
    tick();
    chk("step_k3_note", note_expect, 10'h002);
    chk("step_k3_valid", {9'd0, note_valid}, 10'd1);
  endtask

  task automatic test_random();
    int prev;
    int idx;
    int mid;
    bit hit;
    prev = 2;
    for (int it = 0; it < 12; it++) begin
      do idx = $urandom_range(1, 28); while (idx == prev || model_done(idx));
      if ($urandom_range(0, 1) == 1) begin
        do mid = $urandom_range(1, 28); while (mid == idx || mid == prev || model_done(mid));
        index = 7'(mid);
        repeat ($urandom_range(1, 3)) tick();
      end
      index = 7'(idx);
      hit = 1'b0;
      for (int c = 0; c < 20 && !hit; c++) begin
        tick();
        if (note_valid && note_expect == rom_img[idx-1]) hit = 1'b1;
      end
      total++;
      if (!hit) $display("FAIL rand_note idx=%0d: got %h expected %h", idx, note_expect, rom_img[idx-1]);
      else passed++;
      chk($sformatf("rand_led_%0d", idx), led_hint, rom_img[idx-1]);
      prev = idx;
    end
  endtask

  task automatic test_done();
    bit hit;
    bit saw_valid;
    index = 7'd4;
    hit = 1'b0;
    for (int c = 0; c < 12 && !hit; c++) begin
      tick();
      hit = song_done;
    end
    chk("done_end_code", {9'd0, song_done}, 10'd1);
    chk("done_note", note_expect, 10'h3FF);
    chk("done_led", led_hint, 10'h000);
    index = 7'd1;
    repeat (6) tick();
    chk("done_held", {9'd0, song_done}, 10'd1);
    chk("done_held_valid", {9'd0, note_valid}, 10'd0);
    state = PLAY_MODE;
    tick();
    chk("done_exit", {9'd0, song_done}, 10'd0);
    state = LEARN_MODE; index = 7'd29;
    hit = 1'b0; saw_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (note_valid) saw_valid = 1'b1;
      if (song_done) hit = 1'b1;
    end
    chk("done_range", {9'd0, hit}, 10'd1);
    chk("done_range_novalid", {9'd0, saw_valid}, 10'd0);
    chk("done_range_note", note_expect, 10'h3FF);
    state = IDLE_MODE;
    tick();
  endtask

  task automatic test_boundary();
    index = 7'd0; state = LEARN_MODE;
    repeat (8) tick();
    chk("zero_valid", {9'd0, note_valid}, 10'd0);
    chk("zero_done", {9'd0, song_done}, 10'd0);
    chk("zero_note", note_expect, 10'h3FF);
    index = 7'd28;
    repeat (4) tick();
    chk("last_note", note_expect, rom_img[27]);
    chk("last_valid", {9'd0, note_valid}, 10'd1);
    chk("last_done", {9'd0, song_done}, 10'd0);
  endtask

  task automatic test_exit_wait();
    index = 7'd2;
    tick();
    tick();
    state = PLAY_MODE;
    tick();
    chk("exit_note", note_expect, 10'h3FF);
    chk("exit_valid", {9'd0, note_valid}, 10'd0);
    chk("exit_led", led_hint, 10'h000);
    repeat (5) tick();
    chk("exit_stale", {9'd0, note_valid}, 10'd0);
    state = LEARN_MODE;
    repeat (4) tick();
    chk("reentry_note", note_expect, 10'h002);
  endtask

  task automatic test_reset_mid();
    rst = 1'b0;
    #1;
    chk("areset_note", note_expect, 10'h3FF);
    chk("areset_valid", {9'd0, note_valid}, 10'd0);
    chk("areset_led", led_hint, 10'h000);
    tick();
    rst = 1'b1;
  endtask

  task automatic test_blink();
    logic [9:0] exp;
    index = 7'd1; state = IDLE_MODE;
    tick();
    state = LEARN_MODE;
    repeat (4) tick();
    for (int n = 0; n < 16; n++) begin
      exp = (!BLINK_BUILD || ((n / BDIV) % 2 == 0)) ? 10'h001 : 10'h000;
      chk($sformatf("blink_n%0d", n), led_hint, exp);
      chk($sformatf("blink_note_n%0d", n), note_expect, 10'h001);
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom_img[i] = 10'h200;
    rom_img[0] = 10'h001;
    rom_img[1] = 10'h002;
    rom_img[2] = 10'h004;
    rom_img[3] = 10'h000;
    for (int i = 4; i < 28; i++) rom_img[i] = 10'h100 | 10'(i);

    test_reset();
    test_first_note();
    test_step();
    test_random();
    test_done();
    test_boundary();
    test_blink();
    test_exit_wait();
    test_reset_mid();
    test_blink();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
